// File: rtl/pc_unit_pkg.sv
// Shared command encoding and default reset vector for the program-counter unit.
package pc_unit_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD = 3'd0,
        CMD_INC  = 3'd1,
        CMD_LD   = 3'd2,
        CMD_CALL = 3'd3,
        CMD_RET  = 3'd4
    } cmd_t;

    localparam int unsigned DEFAULT_RESET_VECTOR = 0;

endpackage

// File: rtl/pc_unit_return_stack.sv
// Return-address LIFO for pc_unit. Contents are not cleared on reset; only the
// occupancy count is.
module return_stack #(
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned StackDepth = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Push,
    input  logic                          Pop,
    input  logic [DataWidth-1:0]          PushData,
    output logic                          Full,
    output logic                          Empty,
    output logic [$clog2(StackDepth):0]   Depth,
    output logic [DataWidth-1:0]          Top
);

    localparam int unsigned PtrW = $clog2(StackDepth);

    logic [DataWidth-1:0]  mem [StackDepth];
    logic [PtrW:0]         depth_q;
    logic [PtrW-1:0]       wr_idx;
    logic [PtrW-1:0]       top_idx;
    logic                  do_push;
    logic                  do_pop;

    assign Full    = (depth_q == (PtrW+1)'(StackDepth));
    assign Empty   = (depth_q == '0);
    assign do_push = Push && !Full && !Pop;
    assign do_pop  = Pop && !Empty;
    assign wr_idx  = depth_q[PtrW-1:0];
    // When full the low bits wrap to zero, so subtracting one still lands on the last slot.
    assign top_idx = depth_q[PtrW-1:0] - PtrW'(1);
    assign Top     = mem[top_idx];
    assign Depth   = depth_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            depth_q <= '0;
        end else if (do_push) begin
            depth_q <= depth_q + (PtrW+1)'(1);
        end else if (do_pop) begin
            depth_q <= depth_q - (PtrW+1)'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_idx] <= PushData;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with hold/inc/load/call/return and a return stack.
// Optional stack bounds checking via the PC_UNIT_STACK_CHECK_EN macro.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned DataWidth   = 8,
    parameter int unsigned StackDepth  = 4,
    parameter int unsigned ResetVector = DEFAULT_RESET_VECTOR
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Inc,
    input  logic                        Ld,
    input  logic                        Call,
    input  logic                        Ret,
    input  logic [DataWidth-1:0]        DIn,
    output logic [DataWidth-1:0]        DOut,
    output logic [$clog2(StackDepth):0] Depth,
    output logic                        Overflow,
    output logic                        Underflow
);

    localparam logic [DataWidth-1:0] RESET_PC = DataWidth'(ResetVector);

    cmd_t                 cmd;
    logic [DataWidth-1:0] pc_q;
    logic [DataWidth-1:0] pc_next;
    logic [DataWidth-1:0] pc_plus1;
    logic [DataWidth-1:0] stack_top;
    logic                 stack_full;
    logic                 stack_empty;
    logic                 push;
    logic                 pop;
`ifdef PC_UNIT_STACK_CHECK_EN
    logic                 ovf_set;
    logic                 unf_set;
`endif

    assign pc_plus1 = pc_q + DataWidth'(1);
    assign DOut     = pc_q;

    always_comb begin
        cmd = CMD_HOLD;
        if (Ret)       cmd = CMD_RET;
        else if (Call) cmd = CMD_CALL;
        else if (Ld)   cmd = CMD_LD;
        else if (Inc)  cmd = CMD_INC;
    end

    always_comb begin
        pc_next = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
`ifdef PC_UNIT_STACK_CHECK_EN
        ovf_set = 1'b0;
        unf_set = 1'b0;
`endif
        case (cmd)
            CMD_INC: pc_next = pc_plus1;
            CMD_LD:  pc_next = DIn;
            CMD_CALL: begin
                if (!stack_full) begin
                    push    = 1'b1;
                    pc_next = DIn;
                end else begin
`ifdef PC_UNIT_STACK_CHECK_EN
                    ovf_set = 1'b1;
`else
                    pc_next = DIn;
`endif
                end
            end
            CMD_RET: begin
                if (!stack_empty) begin
                    pop     = 1'b1;
                    pc_next = stack_top;
                end else begin
`ifdef PC_UNIT_STACK_CHECK_EN
                    unf_set = 1'b1;
`else
                    pc_next = RESET_PC;
`endif
                end
            end
            default: pc_next = pc_q;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) pc_q <= RESET_PC;
        else       pc_q <= pc_next;
    end

`ifdef PC_UNIT_STACK_CHECK_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (ovf_set) Overflow  <= 1'b1;
            if (unf_set) Underflow <= 1'b1;
        end
    end
`else
    assign Overflow  = 1'b0;
    assign Underflow = 1'b0;
`endif

    return_stack #(
        .DataWidth (DataWidth),
        .StackDepth(StackDepth)
    ) u_stack (
        .Clk     (Clk),
        .Reset   (Reset),
        .Push    (push),
        .Pop     (pop),
        .PushData(pc_plus1),
        .Full    (stack_full),
        .Empty   (stack_empty),
        .Depth   (Depth),
        .Top     (stack_top)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed sequences followed by random strobes, all checked
// against a queue-based reference model.
module tb_pc_unit;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Inc, Ld, Call, Ret;
    logic [7:0] DIn;
    logic [7:0] DOut;
    logic [2:0] Depth;
    logic       Overflow, Underflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_pc;
    logic [7:0] m_stack[$];
    logic       m_ovf, m_unf;

    pc_unit dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Inc      (Inc),
        .Ld       (Ld),
        .Call     (Call),
        .Ret      (Ret),
        .DIn      (DIn),
        .DOut     (DOut),
        .Depth    (Depth),
        .Overflow (Overflow),
        .Underflow(Underflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pc  = 8'h00;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step();
        if (Ret) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
`ifdef PC_UNIT_STACK_CHECK_EN
            else m_unf = 1'b1;
`else
            else m_pc = 8'h00;
`endif
        end else if (Call) begin
            if (m_stack.size() < 4) begin
                m_stack.push_back(m_pc + 8'd1);
                m_pc = DIn;
            end
`ifdef PC_UNIT_STACK_CHECK_EN
            else m_ovf = 1'b1;
`else
            else m_pc = DIn;
`endif
        end else if (Ld) begin
            m_pc = DIn;
        end else if (Inc) begin
            m_pc = m_pc + 8'd1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dout"},  32'(DOut),      32'(m_pc));
        check({tag, ".depth"}, 32'(Depth),     32'(m_stack.size()));
        check({tag, ".ovf"},   32'(Overflow),  32'(m_ovf));
        check({tag, ".unf"},   32'(Underflow), 32'(m_unf));
    endtask

    task automatic drive(input logic r, input logic c, input logic l, input logic i, input logic [7:0] d);
        Ret = r; Call = c; Ld = l; Inc = i; DIn = d;
    endtask

    task automatic tick(input string tag);
        @(posedge Clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    // Called 1 time unit after a rising edge; reset hits mid-cycle.
    task automatic async_reset(input string tag);
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        drive(0, 0, 0, 0, 8'h00);
        model_reset();
        #3;
        check_all("reset");
        @(negedge Clk);
        Reset = 1'b0;

        drive(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) tick("inc");
        drive(0, 0, 0, 0, 8'h00);
        async_reset("midreset");

        drive(0, 0, 1, 0, 8'hFE); tick("ld_fe");
        drive(0, 0, 0, 1, 8'h00); tick("wrap_ff"); tick("wrap_00");

        drive(0, 0, 1, 0, 8'h40); tick("ld_40");
        drive(0, 1, 0, 0, 8'h80); tick("call_80");
        drive(1, 0, 0, 0, 8'h00); tick("ret_41");

        drive(0, 0, 1, 0, 8'h10); tick("ld_10");
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 8'h20 + 8'(i) * 8'h10);
            tick("nest_call");
        end
        drive(0, 1, 0, 0, 8'h99); tick("call_full");
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 8'h00);
            tick("nest_ret");
        end

        drive(1, 0, 0, 0, 8'h00); tick("ret_empty");
        drive(0, 0, 1, 0, 8'h33); tick("ld_33");
        drive(1, 1, 1, 0, 8'h77); tick("crl_empty");
        drive(0, 1, 0, 0, 8'h60); tick("call_60");
        drive(1, 1, 1, 1, 8'h77); tick("crl_pop");

        drive(0, 0, 0, 0, 8'h00);
        async_reset("rst2");

        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
                  8'($urandom));
            tick("rand");
            if ($urandom_range(0, 60) == 0) async_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
